// File: rtl/sram_ctrl.sv
// sram_ctrl: 32-bit load/store bridge to a 16-bit SRAM, low half-word then high half-word
module sram_ctrl #(
  parameter int          WAIT_CYCLES = 2,
  parameter logic [31:0] BASE_ADDR   = 32'd1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rd_en,
  input  logic        wr_en,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        ready,
  output logic [17:0] sram_addr,
  output logic [15:0] sram_dq_out,
  output logic        sram_dq_oe,
  input  logic [15:0] sram_dq_in,
  output logic        sram_we_n
);
  typedef enum logic [1:0] {IDLE, LOW, HIGH, DONE} state_t;
  state_t      state, next;
  logic [3:0]  cnt;
  logic        is_wr;
  logic [15:0] wdata_hi;
  logic [16:0] w;
  logic        req, tc, active;
  assign req    = rd_en | wr_en;
  assign w      = 17'((address - BASE_ADDR) >> 2);
  assign tc     = cnt == 4'(WAIT_CYCLES - 1);
  assign active = state == LOW || state == HIGH;
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= IDLE;
    else state <= next;
  always_comb
    next = state == IDLE ? (req ? LOW : IDLE) :
           state == LOW  ? (tc ? HIGH : LOW) :
           state == HIGH ? (tc ? DONE : HIGH) : IDLE;
  always_comb begin
    ready      = state == DONE || (state == IDLE && !req);
    sram_dq_oe = active && is_wr;
    sram_we_n  = !(active && is_wr);
  end
  // sram_addr[17:1] keeps the latched word index, so the high phase only flips bit 0
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      cnt         <= '0;
      is_wr       <= 1'b0;
      wdata_hi    <= '0;
      sram_addr   <= '0;
      sram_dq_out <= '0;
      read_data   <= '0;
    end else if (state == IDLE && req) begin
      cnt         <= '0;
      is_wr       <= wr_en;
      wdata_hi    <= write_data[31:16];
      sram_addr   <= {w, 1'b0};
      sram_dq_out <= write_data[15:0];
    end else if (active) begin
      cnt <= tc ? 4'd0 : cnt + 4'd1;
      if (tc && !is_wr && state == LOW) read_data[15:0] <= sram_dq_in;
      if (tc && !is_wr && state == HIGH) read_data[31:16] <= sram_dq_in;
      if (tc && state == LOW) begin
        sram_addr[0] <= 1'b1;
        sram_dq_out  <= wdata_hi;
      end
    end
endmodule

// File: tb/tb_sram_ctrl.sv
// tb_sram_ctrl: table-driven accesses with a read-data scoreboard, plus reset-abort and wrap sequences
module tb_sram_ctrl;
  localparam int W = 2;
  logic        clk = 1'b0;
  logic        rst, load;
  logic        rd_en, wr_en;
  logic [31:0] address, write_data, read_data;
  logic        ready, sram_dq_oe, sram_we_n;
  logic [17:0] sram_addr;
  logic [15:0] sram_dq_out, sram_dq_in;
  logic [15:0] mem [0:262143];
  logic        rd1, wr1;
  logic [31:0] addr1, wd1, rdata1;
  logic        ready1, oe1, we1_n;
  logic [17:0] sa1;
  logic [15:0] dqo1, dqi1;
  logic [15:0] mem1 [0:262143];
  int          checks = 0, errors = 0;
  logic [17:0] last_addr;
  typedef struct {logic rd; logic wr; logic [31:0] a; logic [31:0] wd; logic [31:0] exp_rd; int gap;} vec_t;
  typedef struct {logic [31:0] rdata; int lat;} exp_t;
  vec_t v [7];
  exp_t sb [$];

  sram_ctrl #(.WAIT_CYCLES(W), .BASE_ADDR(32'd1024)) dut (
    .clk(clk), .rst(rst), .rd_en(rd_en), .wr_en(wr_en), .address(address),
    .write_data(write_data), .read_data(read_data), .ready(ready), .sram_addr(sram_addr),
    .sram_dq_out(sram_dq_out), .sram_dq_oe(sram_dq_oe), .sram_dq_in(sram_dq_in), .sram_we_n(sram_we_n));
  sram_ctrl #(.WAIT_CYCLES(1), .BASE_ADDR(32'd1024)) dut1 (
    .clk(clk), .rst(rst), .rd_en(rd1), .wr_en(wr1), .address(addr1),
    .write_data(wd1), .read_data(rdata1), .ready(ready1), .sram_addr(sa1),
    .sram_dq_out(dqo1), .sram_dq_oe(oe1), .sram_dq_in(dqi1), .sram_we_n(we1_n));

  always #5 clk = ~clk;
  assign sram_dq_in = mem[sram_addr];
  assign dqi1 = mem1[sa1];
  always @(posedge clk)
    if (load) begin
      mem[2] <= 16'h1234;
      mem[3] <= 16'hABCD;
      mem[9] <= 16'h0000;
    end else if (!sram_we_n) mem[sram_addr] <= sram_dq_out;
  always @(posedge clk)
    if (!we1_n) mem1[sa1] <= dqo1;

  task automatic check(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      rd_en = 1'b0;
      wr_en = 1'b0;
      #1;
      check("idle_ready", ready, 1);
      check("idle_we_n", sram_we_n, 1);
      check("idle_oe", sram_dq_oe, 0);
      check("idle_addr_hold", sram_addr, last_addr);
    end
  endtask

  task automatic run(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] wd,
                     input logic [31:0] exp_rd);
    logic [16:0] w;
    logic [17:0] ea;
    exp_t e;
    int c;
    @(negedge clk);
    rd_en = rd;
    wr_en = wr;
    address = a;
    write_data = wd;
    w = 17'((a - 32'd1024) >> 2);
    sb.push_back('{exp_rd, 2 * W + 1});
    #1 check("ready_req_idle", ready, 0);
    for (c = 1; c <= 60; c++) begin
      @(negedge clk);
      rd_en = 1'($urandom);
      wr_en = 1'($urandom);
      address = $urandom;
      write_data = $urandom;
      #1;
      if (ready) break;
      ea = (c <= W) ? {w, 1'b0} : {w, 1'b1};
      check("busy_addr", sram_addr, ea);
      check("busy_we_n", sram_we_n, !wr);
      check("busy_oe", sram_dq_oe, wr);
      if (wr) check("busy_dq", sram_dq_out, (c <= W) ? wd[15:0] : wd[31:16]);
    end
    e = sb.pop_front();
    check("latency", c, e.lat);
    check("read_data", read_data, e.rdata);
    last_addr = {w, 1'b1};
  endtask

  initial begin
    v[0] = '{1'b0, 1'b1, 32'd1024, 32'hDEADBEEF, 32'h00000000, 0};
    v[1] = '{1'b1, 1'b0, 32'd1028, 32'h0,        32'hABCD1234, 0};
    v[2] = '{1'b1, 1'b0, 32'd1024, 32'h0,        32'hDEADBEEF, 2};
    v[3] = '{1'b1, 1'b1, 32'd1032, 32'h0BADF00D, 32'hDEADBEEF, 0};
    v[4] = '{1'b1, 1'b0, 32'd1032, 32'h0,        32'h0BADF00D, 1};
    v[5] = '{1'b0, 1'b1, 32'd1424, 32'h13579BDF, 32'h0BADF00D, 0};
    v[6] = '{1'b1, 1'b0, 32'd1424, 32'h0,        32'h13579BDF, 0};
    rst = 1'b0; load = 1'b1;
    rd_en = 1'b0; wr_en = 1'b0; address = '0; write_data = '0;
    rd1 = 1'b0; wr1 = 1'b0; addr1 = '0; wd1 = '0;
    last_addr = '0;
    repeat (2) @(negedge clk);
    #1;
    check("rst_read_data", read_data, 0);
    check("rst_sram_addr", sram_addr, 0);
    check("rst_dq_out", sram_dq_out, 0);
    check("rst_we_n", sram_we_n, 1);
    check("rst_oe", sram_dq_oe, 0);
    check("rst_ready_idle", ready, 1);
    rd_en = 1'b1;
    #1 check("rst_ready_req", ready, 0);
    rd_en = 1'b0;
    @(negedge clk);
    rst = 1'b1; load = 1'b0;
    // address 1020 sits one word below the base and wraps to the top of the SRAM
    @(negedge clk);
    wr1 = 1'b1; addr1 = 32'd1020; wd1 = 32'h55AA33CC;
    #1 check("w1_ready_c0", ready1, 0);
    @(negedge clk); wr1 = 1'b0;
    #1 check("w1_addr_lo", sa1, 18'h3FFFE);
    check("w1_dq_lo", dqo1, 16'h33CC);
    check("w1_we_lo", we1_n, 0);
    @(negedge clk);
    #1 check("w1_addr_hi", sa1, 18'h3FFFF);
    check("w1_dq_hi", dqo1, 16'h55AA);
    @(negedge clk);
    #1 check("w1_ready_c3", ready1, 1);
    @(negedge clk); rd1 = 1'b1;
    #1 check("r1_ready_c0", ready1, 0);
    @(negedge clk); rd1 = 1'b0;
    @(negedge clk);
    #1 check("r1_ready_c2", ready1, 0);
    @(negedge clk);
    #1 check("r1_ready_c3", ready1, 1);
    check("r1_read_data", rdata1, 32'h55AA33CC);
    for (int i = 0; i < 7; i++) begin
      idle(v[i].gap);
      run(v[i].rd, v[i].wr, v[i].a, v[i].wd, v[i].exp_rd);
    end
    idle(2);
    check("mem0", mem[0], 16'hBEEF);
    check("mem1", mem[1], 16'hDEAD);
    check("mem4", mem[4], 16'hF00D);
    check("mem5", mem[5], 16'h0BAD);
    @(negedge clk);
    wr_en = 1'b1; rd_en = 1'b0; address = 32'd1040; write_data = 32'hCAFEF00D;
    @(negedge clk); wr_en = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1 check("abort_pre_addr", sram_addr, 18'd9);
    check("abort_pre_we_n", sram_we_n, 0);
    rst = 1'b0; wr_en = 1'b1;
    #1 check("abort_we_n", sram_we_n, 1);
    check("abort_oe", sram_dq_oe, 0);
    check("abort_addr", sram_addr, 0);
    check("abort_ready_req", ready, 0);
    wr_en = 1'b0;
    #1 check("abort_ready_idle", ready, 1);
    @(negedge clk); rst = 1'b1;
    check("abort_mem_lo", mem[8], 16'hF00D);
    check("abort_mem_hi", mem[9], 16'h0000);
    run(1'b1, 1'b0, 32'd1040, 32'h0, 32'h0000F00D);
    idle(1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
